// File: rtl/feature_frame_buffer_if.sv
// Serial feature-sample stream into the frame buffer.
// master: sample producer; slave: feature_frame_buffer.
interface feature_frame_buffer_if #(
    parameter int IN_W = 12
) ();
    logic            s_valid;
    logic            s_ready;
    logic [IN_W-1:0] s_data;
    logic            s_sof;

    modport master (output s_valid, output s_data, output s_sof, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_sof, output s_ready);
endinterface

// File: rtl/feature_frame_buffer.sv
// Collects a serial sample stream into an N-entry frame and launches the
// drowsiness detector on it. The launched frame is double-buffered in
// feat_out_o, so the next frame fills while the detector runs.
module feature_frame_buffer #(
    parameter int N       = 30,
    parameter int W       = 10,
    parameter int IN_W    = 12,
    parameter int MAX_VAL = 1023,
    parameter int CNT_W   = 16
) (
    input  logic                  clock_i,
    input  logic                  rst_n_i,
    feature_frame_buffer_if.slave s_if,
    output logic [N*W-1:0]        feat_out_o,
    output logic                  start_o,
    input  logic                  det_done_i,
    output logic                  det_busy_o,
    output logic [CNT_W-1:0]      frame_cnt_o,
    output logic [7:0]            sof_err_cnt_o
);

    localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [IN_W-1:0]   MAX_IN   = IN_W'(MAX_VAL);
    localparam logic [W-1:0]      MAX_OUT  = W'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE_FILL,
        RUN_FILL,
        FULL
    } state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        fill_q [N];
    logic [W-1:0]        fill_d [N];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          sof_err_q, sof_err_d;
    logic [CNT_W-1:0]    frame_cnt_q;
    logic [N*W-1:0]      feat_out_q, feat_launch;
    logic                start_q, det_busy_q, s_ready_q;
    logic                accept, complete, launch, done_ok;
    logic [W-1:0]        sample;

    assign accept = s_if.s_valid && s_ready_q;
    assign sample = (s_if.s_data > MAX_IN) ? MAX_OUT : s_if.s_data[W-1:0];
    // A done pulse only counts once the detector has been started and is not in its start cycle.
    assign done_ok = det_done_i && det_busy_q && !start_q;

    // Fill-buffer write, fill index and early-SOF accounting for each accepted sample.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        fill_d    = fill_q;
        idx_d     = idx_q;
        sof_err_d = sof_err_q;
        complete  = 1'b0;
        if (accept) begin
            if (s_if.s_sof) begin
                fill_d[0] = sample;
                if (idx_q != '0 && sof_err_q != 8'hFF) begin
                    sof_err_d = sof_err_q + 8'd1;
                end
                if (N == 1) begin
                    complete = 1'b1;
                    idx_d    = '0;
                end else begin
                    idx_d = IDX_W'(1);
                end
            end else if (idx_q != '0) begin
                fill_d[idx_q] = sample;
                if (idx_q == LAST_IDX) begin
                    complete = 1'b1;
                    idx_d    = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    // Flatten the fill buffer (including a completing sample) into the launch image.
    always_comb begin
        feat_launch = '0;
        for (int i = 0; i < N; i++) begin
            feat_launch[i*W +: W] = fill_d[i];
        end
    end

    // Next-state and launch decision.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE_FILL: begin
                if (complete) begin
                    launch  = 1'b1;
                    state_d = RUN_FILL;
                end
            end
            RUN_FILL: begin
                if (complete && done_ok) begin
                    launch = 1'b1;
                end else if (complete) begin
                    state_d = FULL;
                end else if (done_ok) begin
                    state_d = IDLE_FILL;
                end
            end
            FULL: begin
                // s_ready is low here, so fill_d equals the held frame.
                if (done_ok) begin
                    launch  = 1'b1;
                    state_d = RUN_FILL;
                end
            end
            default: state_d = IDLE_FILL;
        endcase
    end

    // State, buffers, counters and registered handshake outputs.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (!rst_n_i) begin
            state_q     <= IDLE_FILL;
            idx_q       <= '0;
            sof_err_q   <= '0;
            frame_cnt_q <= '0;
            feat_out_q  <= '0;
            start_q     <= 1'b0;
            det_busy_q  <= 1'b0;
            s_ready_q   <= 1'b0;
            // NOTE: the fill buffer is small and must read as empty after reset, so it is reset like any flop.
            for (int i = 0; i < N; i++) begin
                fill_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sof_err_q  <= sof_err_d;
            fill_q     <= fill_d;
            start_q    <= launch;
            det_busy_q <= (state_d != IDLE_FILL);
            s_ready_q  <= (state_d != FULL);
            if (launch) begin
                feat_out_q  <= feat_launch;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    assign s_if.s_ready  = s_ready_q;
    assign feat_out_o    = feat_out_q;
    assign start_o       = start_q;
    assign det_busy_o    = det_busy_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign sof_err_cnt_o = sof_err_q;

endmodule
